control_unit: RTL and testbench

//  Multi-cycle fetch/decode/sequencing FSM sitting directly upstream of the ADD-SUB datapath.

---
 rtl/control_unit_pkg.sv | 47 ++++
 rtl/control_unit_instr_decoder.sv | 64 ++++++
 rtl/control_unit.sv | 86 ++++++++
 tb/tb_control_unit.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/control_unit_pkg.sv
// rtl/control_unit_pkg.sv - shared RV64I encodings, FSM states and decode record for control_unit
package control_unit_pkg;

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_DECODE = 2'd1,
        S_EXEC   = 2'd2,
        S_TRAP   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        IMM_NONE = 2'd0,
        IMM_I    = 2'd1,
        IMM_S    = 2'd2
    } imm_sel_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [2:0] F3_ADD    = 3'b000;
    localparam logic [2:0] F3_DWORD  = 3'b011;
    localparam logic [6:0] F7_ADD    = 7'b0000000;
    localparam logic [6:0] F7_SUB    = 7'b0100000;

    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [11:0] imm;
        logic        sub;
        logic        r_type;
        logic        i_type;
        logic        wr_rf;
        logic        wr_mem;
        logic        illegal;
    } dec_t;

    function automatic logic [11:0] imm_extract(input logic [31:0] instr, input imm_sel_t sel);
        case (sel)
            IMM_I:   imm_extract = instr[31:20];
            IMM_S:   imm_extract = {instr[31:25], instr[11:7]};
            default: imm_extract = 12'd0;
        endcase
    endfunction

endpackage

// File: rtl/control_unit_instr_decoder.sv
// rtl/control_unit_instr_decoder.sv - combinational ADD/SUB/ADDI/LD/SD decoder
module control_unit_instr_decoder
    import control_unit_pkg::*;
(
    input  logic [31:0] instr,
    output dec_t        dec
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    imm_sel_t   imm_sel;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    always_comb begin
        dec         = '0;
        imm_sel     = IMM_NONE;
        dec.rs1     = instr[19:15];
        dec.rs2     = instr[24:20];
        dec.rd      = instr[11:7];
        dec.illegal = 1'b1;
        case (opcode)
            OP_R: begin
                if (funct3 == F3_ADD && (funct7 == F7_ADD || funct7 == F7_SUB)) begin
                    dec.illegal = 1'b0;
                    dec.r_type  = 1'b1;
                    dec.sub     = (funct7 == F7_SUB);
                    dec.wr_rf   = 1'b1;
                end
            end
            OP_IMM: begin
                if (funct3 == F3_ADD) begin
                    dec.illegal = 1'b0;
                    dec.r_type  = 1'b1;
                    dec.i_type  = 1'b1;
                    dec.wr_rf   = 1'b1;
                    imm_sel     = IMM_I;
                end
            end
            OP_LOAD: begin
                if (funct3 == F3_DWORD) begin
                    dec.illegal = 1'b0;
                    dec.i_type  = 1'b1;
                    dec.wr_rf   = 1'b1;
                    imm_sel     = IMM_I;
                end
            end
            OP_STORE: begin
                if (funct3 == F3_DWORD) begin
                    dec.illegal = 1'b0;
                    dec.i_type  = 1'b1;
                    dec.wr_mem  = 1'b1;
                    imm_sel     = IMM_S;
                end
            end
            default: ;
        endcase
        dec.imm = imm_extract(instr, imm_sel);
    end

endmodule

// File: rtl/control_unit.sv
// rtl/control_unit.sv - multi-cycle fetch/decode/exec sequencer for the ADD-SUB datapath
module control_unit
    import control_unit_pkg::*;
#(
    parameter int                PC_W     = 32,
    parameter logic [PC_W-1:0]   RESET_PC = '0,
    parameter int                CNT_W    = 32
) (
    input  logic              CLK,
    input  logic              RST,
    output logic              IM_REQ,
    output logic [PC_W-1:0]   IM_ADDR,
    input  logic              IM_ACK,
    input  logic [31:0]       IM_RDATA,
    output logic [4:0]        rs1,
    output logic [4:0]        rs2,
    output logic [4:0]        rd,
    output logic [11:0]       immediate,
    output logic              sub,
    output logic              WE_RF,
    output logic              WE_MEM,
    output logic              R_type,
    output logic              I_type,
    output logic [PC_W-1:0]   PC,
    output logic              ILLEGAL,
    output logic [CNT_W-1:0]  RETIRED
);

    state_t      state;
    logic [31:0] ir;
    dec_t        dec;
    logic        active;

    control_unit_instr_decoder u_decoder (
        .instr (ir),
        .dec   (dec)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= S_FETCH;
            PC      <= RESET_PC;
            ir      <= '0;
            RETIRED <= '0;
            ILLEGAL <= 1'b0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (IM_ACK) begin
                        ir    <= IM_RDATA;
                        state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (dec.illegal) begin
                        ILLEGAL <= 1'b1;
                        state   <= S_TRAP;
                    end else begin
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    PC      <= PC + PC_W'(4);
                    RETIRED <= RETIRED + CNT_W'(1);
                    state   <= S_FETCH;
                end
                default: state <= S_TRAP;
            endcase
        end
    end

    // Controls are derived from registered state and IR only, so async reset zeroes them at once.
    assign active    = (state == S_DECODE) || (state == S_EXEC);
    assign IM_REQ    = (state == S_FETCH);
    assign IM_ADDR   = PC;
    assign rs1       = active ? dec.rs1 : 5'd0;
    assign rs2       = active ? dec.rs2 : 5'd0;
    assign rd        = active ? dec.rd  : 5'd0;
    assign immediate = active ? dec.imm : 12'd0;
    assign sub       = active & dec.sub;
    assign R_type    = active & dec.r_type;
    assign I_type    = active & dec.i_type;
    assign WE_RF     = (state == S_EXEC) & dec.wr_rf & (dec.rd != 5'd0);
    assign WE_MEM    = (state == S_EXEC) & dec.wr_mem;

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - directed self-checking bench for control_unit
module tb_control_unit;

    logic        CLK;
    logic        RST;
    logic        IM_REQ;
    logic [31:0] IM_ADDR;
    logic        IM_ACK;
    logic [31:0] IM_RDATA;
    logic [4:0]  rs1, rs2, rd;
    logic [11:0] immediate;
    logic        sub, WE_RF, WE_MEM, R_type, I_type;
    logic [31:0] PC;
    logic        ILLEGAL;
    logic [31:0] RETIRED;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_pc;
    logic [31:0] exp_ret;

    control_unit dut (
        .CLK (CLK), .RST (RST),
        .IM_REQ (IM_REQ), .IM_ADDR (IM_ADDR), .IM_ACK (IM_ACK), .IM_RDATA (IM_RDATA),
        .rs1 (rs1), .rs2 (rs2), .rd (rd), .immediate (immediate),
        .sub (sub), .WE_RF (WE_RF), .WE_MEM (WE_MEM), .R_type (R_type), .I_type (I_type),
        .PC (PC), .ILLEGAL (ILLEGAL), .RETIRED (RETIRED)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Entered on a negedge in FETCH; returns on the negedge of the DECODE cycle.
    task automatic fetch(input logic [31:0] word, input int waits);
        chk("fetch_req", IM_REQ, 1);
        chk("fetch_addr", IM_ADDR, exp_pc);
        for (int i = 0; i < waits; i++) begin
            @(negedge CLK);
            chk("wait_req", IM_REQ, 1);
            chk("wait_addr", IM_ADDR, exp_pc);
            chk("wait_we", {WE_RF, WE_MEM}, 0);
        end
        IM_ACK   = 1'b1;
        IM_RDATA = word;
        @(negedge CLK);
        IM_ACK   = 1'b0;
        IM_RDATA = 32'hDEAD_BEEF;
        chk("decode_we", {WE_RF, WE_MEM}, 0);
        chk("decode_req", IM_REQ, 0);
    endtask

    initial begin
        RST      = 1'b1;
        IM_ACK   = 1'b0;
        IM_RDATA = 32'h0;
        exp_pc   = 32'h0;
        exp_ret  = 32'h0;
        @(negedge CLK);
        chk("rst_pc", PC, 0);
        chk("rst_ret", RETIRED, 0);
        chk("rst_ill", ILLEGAL, 0);
        chk("rst_ctl", {WE_RF, WE_MEM, sub, R_type, I_type, rs1, rs2, rd, immediate}, 0);
        RST = 1'b0;
        @(negedge CLK);

        // 1: ADD x3,x1,x2 acked immediately
        fetch(32'h002081B3, 0);
        chk("add_rs1", rs1, 1);
        chk("add_rs2", rs2, 2);
        chk("add_rd", rd, 3);
        chk("add_ctl", {R_type, I_type, sub}, 3'b100);
        @(negedge CLK);
        chk("add_we", {WE_RF, WE_MEM}, 2'b10);
        chk("add_pc_exec", PC, 0);
        @(negedge CLK);
        exp_pc = 4; exp_ret = 1;
        chk("add_pc", PC, exp_pc);
        chk("add_ret", RETIRED, exp_ret);
        chk("add_we_off", {WE_RF, WE_MEM}, 0);

        // 2: SUB, with a stray ack during DECODE/EXEC that must be ignored
        fetch(32'h402081B3, 0);
        chk("sub_sub", sub, 1);
        IM_ACK = 1'b1; IM_RDATA = 32'h00100013;
        @(negedge CLK);
        chk("sub_ignore_ack", {rs1, rs2, rd, sub}, {5'd1, 5'd2, 5'd3, 1'b1});
        chk("sub_we", WE_RF, 1);
        IM_ACK = 1'b0;
        @(negedge CLK);
        exp_pc = 8; exp_ret = 2;
        chk("sub_pc", PC, exp_pc);

        fetch(32'hFFF00293, 0);
        chk("addi_ctl", {R_type, I_type, sub}, 3'b110);
        chk("addi_imm", immediate, 12'hFFF);
        chk("addi_rd_rs1", {rd, rs1}, {5'd5, 5'd0});
        @(negedge CLK);
        chk("addi_we", {WE_RF, WE_MEM}, 2'b10);
        @(negedge CLK);
        exp_pc = 12; exp_ret = 3;
        chk("addi_pc", PC, exp_pc);
        chk("addi_ret", RETIRED, exp_ret);

        // 3: LD x6,8(x1) and SD x2,16(x1)
        fetch(32'h0080B303, 0);
        chk("ld_ctl", {R_type, I_type, sub}, 3'b010);
        chk("ld_imm", immediate, 8);
        chk("ld_rd", rd, 6);
        @(negedge CLK);
        chk("ld_we", {WE_RF, WE_MEM}, 2'b10);
        @(negedge CLK);
        exp_pc = 16; exp_ret = 4;

        fetch(32'h0020B823, 0);
        chk("sd_imm", immediate, 16);
        chk("sd_rs", {rs1, rs2}, {5'd1, 5'd2});
        chk("sd_ctl", {R_type, I_type}, 2'b01);
        @(negedge CLK);
        chk("sd_we", {WE_RF, WE_MEM}, 2'b01);
        @(negedge CLK);
        exp_pc = 20; exp_ret = 5;
        chk("sd_pc", PC, exp_pc);
        chk("sd_ret", RETIRED, exp_ret);

        // 4: ADDI x0,x0,1 after a 4-cycle ack delay; x0 never written
        fetch(32'h00100013, 4);
        chk("x0_rd", rd, 0);
        @(negedge CLK);
        chk("x0_we", {WE_RF, WE_MEM}, 0);
        @(negedge CLK);
        exp_pc = 24; exp_ret = 6;
        chk("x0_pc", PC, exp_pc);
        chk("x0_ret", RETIRED, exp_ret);

        // 5: all-zero word traps
        fetch(32'h00000000, 0);
        chk("ill_pre", ILLEGAL, 0);
        IM_ACK = 1'b1; IM_RDATA = 32'h002081B3;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            chk("trap_ill", ILLEGAL, 1);
            chk("trap_req", IM_REQ, 0);
            chk("trap_pc", PC, exp_pc);
            chk("trap_ret", RETIRED, exp_ret);
            chk("trap_we", {WE_RF, WE_MEM}, 0);
        end
        IM_ACK = 1'b0;

        // 6: reset clears TRAP, then async reset during EXEC of ADD
        RST = 1'b1;
        #1;
        chk("trap_rst_ill", ILLEGAL, 0);
        chk("trap_rst_req", IM_REQ, 1);
        @(negedge CLK);
        RST = 1'b0;
        exp_pc = 0; exp_ret = 0;
        @(negedge CLK);
        fetch(32'h002081B3, 0);
        @(negedge CLK);
        chk("mid_we", WE_RF, 1);
        #2;
        RST = 1'b1;
        #1;
        chk("mid_we_off", {WE_RF, WE_MEM}, 0);
        chk("mid_ctl", {sub, R_type, I_type, rs1, rs2, rd, immediate}, 0);
        chk("mid_pc", PC, 0);
        chk("mid_ret", RETIRED, 0);
        @(negedge CLK);
        chk("mid_hold_we", WE_RF, 0);
        RST = 1'b0;
        @(negedge CLK);
        fetch(32'hFFF00293, 0);
        @(negedge CLK);
        chk("post_we", WE_RF, 1);
        @(negedge CLK);
        chk("post_pc", PC, 4);
        chk("post_ret", RETIRED, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
